// File: rtl/aib_bsr_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aib_bsr_scan_ctrl
//  Purpose  : Boundary-scan sequencer for the AIB IO boundary-scan/redundancy
//             wrapper chain. On a start request it puts the wrapper in JTAG
//             mode and shifts op_len bits of tx_data (LSB first) through the
//             TX scan chain on a divided scan clock. It captures the returning
//             RX bits, then issues one update pulse with shift disabled.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   system clock
//    rst_n             in   asynchronous active-low reset
//    start             in   request pulse, accepted only when idle
//    abort             in   terminate the operation in progress
//    op_len            in   bits to shift (1..MAX_LEN), sampled with start
//    tx_data           in   pattern, bit 0 shifted first, sampled with start
//    intest_req        in   jtag_intest value for the operation
//    busy              out  operation in progress
//    done              out  one-cycle completion pulse
//    err               out  one-cycle pulse: abort or bad op_len
//    rx_data           out  captured bits, rx_data[i] = i-th sampled bit
//    jtag_mode_in      out  wrapper JTAG mode
//    jtag_intest       out  wrapper intest select
//    jtag_tx_scanen_in out  shift enable
//    jtag_clkdr_in     out  boundary-scan clock
//    jtag_tx_scan_in   out  serial data into the chain
//    jtag_rx_scan_out  in   serial data out of the chain
// ============================================================================
module aib_bsr_scan_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int DIV     = 2,
  parameter int LW      = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LW-1:0]      op_len,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               intest_req,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               jtag_mode_in,
  output logic               jtag_intest,
  output logic               jtag_tx_scanen_in,
  output logic               jtag_clkdr_in,
  output logic               jtag_tx_scan_in,
  input  logic               jtag_rx_scan_out
);

  localparam int            IW          = $clog2(MAX_LEN);
  localparam int            PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LW-1:0] C_MAX_LEN   = LW'(MAX_LEN);
  localparam logic [PW-1:0] C_PHASE_END = PW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SH_LO = 3'd1,
    S_SH_HI = 3'd2,
    S_UP_LO = 3'd3,
    S_UP_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [PW-1:0]      r_phase,  w_phase_nxt;
  logic [MAX_LEN-1:0] r_txsr,   w_txsr_nxt;
  logic [LW-1:0]      r_cnt,    w_cnt_nxt;
  logic [IW-1:0]      r_idx,    w_idx_nxt;
  logic [MAX_LEN-1:0] r_rx,     w_rx_nxt;
  logic               r_intest, w_intest_nxt;

  // Output registers: every port below is a flop, loaded with the value
  // decoded from the next state so it appears in the same cycle the state
  // does, without any combinational path from inputs to the wrapper pins.
  logic r_busy,   w_busy_nxt;
  logic r_done,   w_done_nxt;
  logic r_err,    w_err_nxt;
  logic r_mode,   w_mode_nxt;
  logic r_jint,   w_jint_nxt;
  logic r_scanen, w_scanen_nxt;
  logic r_clkdr,  w_clkdr_nxt;
  logic r_scanin, w_scanin_nxt;

  logic w_phase_end;
  logic w_active;
  logic w_len_bad;

  assign w_phase_end = (r_phase == C_PHASE_END);
  assign w_active    = (r_state == S_SH_LO) || (r_state == S_SH_HI) ||
                       (r_state == S_UP_LO) || (r_state == S_UP_HI);
  assign w_len_bad   = (op_len == '0) || (op_len > C_MAX_LEN);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, datapath and next-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_txsr_nxt   = r_txsr;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_rx_nxt     = r_rx;
    w_intest_nxt = r_intest;
    w_err_nxt    = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_mode_nxt   = 1'b0;
    w_jint_nxt   = 1'b0;
    w_scanen_nxt = 1'b0;
    w_clkdr_nxt  = 1'b0;
    w_scanin_nxt = 1'b0;

    // Every active phase lasts DIV cycles; the counter wraps on phase change.
    if (w_active) begin
      w_phase_nxt = w_phase_end ? '0 : (r_phase + PW'(1));
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_SH_LO;
            w_phase_nxt  = '0;
            w_txsr_nxt   = tx_data;
            w_cnt_nxt    = op_len;
            w_intest_nxt = intest_req;
            w_rx_nxt     = '0;
            w_idx_nxt    = '0;
          end
        end
      end
      S_SH_LO: begin
        // Leaving SH_LO is the clkdr rising edge: sample the chain output.
        if (w_phase_end) begin
          w_state_nxt         = S_SH_HI;
          w_rx_nxt[r_idx]     = jtag_rx_scan_out;
          w_idx_nxt           = r_idx + IW'(1);
        end
      end
      S_SH_HI: begin
        // Leaving SH_HI is the clkdr falling edge: present the next bit.
        if (w_phase_end) begin
          w_txsr_nxt  = {1'b0, r_txsr[MAX_LEN-1:1]};
          w_cnt_nxt   = r_cnt - LW'(1);
          w_state_nxt = (r_cnt == LW'(1)) ? S_UP_LO : S_SH_LO;
        end
      end
      S_UP_LO: begin
        if (w_phase_end) begin
          w_state_nxt = S_UP_HI;
        end
      end
      S_UP_HI: begin
        if (w_phase_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides any phase transition on the same edge, including a
    // pending sample, so rx_data keeps only the bits already captured.
    if (abort && w_active) begin
      w_state_nxt = S_IDLE;
      w_phase_nxt = '0;
      w_txsr_nxt  = r_txsr;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_rx_nxt    = r_rx;
      w_err_nxt   = 1'b1;
    end

    case (w_state_nxt)
      S_SH_LO: begin
        w_busy_nxt   = 1'b1;
        w_mode_nxt   = 1'b1;
        w_scanen_nxt = 1'b1;
        w_scanin_nxt = w_txsr_nxt[0];
      end
      S_SH_HI: begin
        w_busy_nxt   = 1'b1;
        w_mode_nxt   = 1'b1;
        w_scanen_nxt = 1'b1;
        w_clkdr_nxt  = 1'b1;
        w_scanin_nxt = w_txsr_nxt[0];
      end
      S_UP_LO: begin
        w_busy_nxt = 1'b1;
        w_mode_nxt = 1'b1;
      end
      S_UP_HI: begin
        w_busy_nxt  = 1'b1;
        w_mode_nxt  = 1'b1;
        w_clkdr_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase

    w_jint_nxt = w_busy_nxt & w_intest_nxt;
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= '0;
      r_txsr   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rx     <= '0;
      r_intest <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mode   <= 1'b0;
      r_jint   <= 1'b0;
      r_scanen <= 1'b0;
      r_clkdr  <= 1'b0;
      r_scanin <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_txsr   <= w_txsr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_rx     <= w_rx_nxt;
      r_intest <= w_intest_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_mode   <= w_mode_nxt;
      r_jint   <= w_jint_nxt;
      r_scanen <= w_scanen_nxt;
      r_clkdr  <= w_clkdr_nxt;
      r_scanin <= w_scanin_nxt;
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;
  assign rx_data           = r_rx;
  assign jtag_mode_in      = r_mode;
  assign jtag_intest       = r_jint;
  assign jtag_tx_scanen_in = r_scanen;
  assign jtag_clkdr_in     = r_clkdr;
  assign jtag_tx_scan_in   = r_scanin;

endmodule
`default_nettype wire

// File: tb/tb_aib_bsr_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_aib_bsr_scan_ctrl
//  Purpose  : Self-checking bench for aib_bsr_scan_ctrl. Two instances share
//             stimulus (DIV=2 and DIV=1, MAX_LEN=8), each with its own
//             8-bit scan-chain model. Expected pin values are computed per
//             cycle from the operation timeline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aib_bsr_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] op_len;
  logic [7:0] tx_data;
  logic       intest_req;

  logic       busy0, done0, err0, mode0, jint0, scanen0, clkdr0, scanin0, rxso0;
  logic       busy1, done1, err1, mode1, jint1, scanen1, clkdr1, scanin1, rxso1;
  logic [7:0] rx0, rx1;
  logic [7:0] o0, o1;

  logic [7:0] chain0, chain1, pre0, pre1;
  logic       ld;

  logic [7:0] rxp0, rxp1;
  int         checks;
  int         errors;

  aib_bsr_scan_ctrl #(.MAX_LEN(8), .DIV(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_len(op_len),
    .tx_data(tx_data), .intest_req(intest_req), .busy(busy0), .done(done0),
    .err(err0), .rx_data(rx0), .jtag_mode_in(mode0), .jtag_intest(jint0),
    .jtag_tx_scanen_in(scanen0), .jtag_clkdr_in(clkdr0),
    .jtag_tx_scan_in(scanin0), .jtag_rx_scan_out(rxso0)
  );

  aib_bsr_scan_ctrl #(.MAX_LEN(8), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_len(op_len),
    .tx_data(tx_data), .intest_req(intest_req), .busy(busy1), .done(done1),
    .err(err1), .rx_data(rx1), .jtag_mode_in(mode1), .jtag_intest(jint1),
    .jtag_tx_scanen_in(scanen1), .jtag_clkdr_in(clkdr1),
    .jtag_tx_scan_in(scanin1), .jtag_rx_scan_out(rxso1)
  );

  assign o0 = {busy0, done0, err0, mode0, jint0, scanen0, clkdr0, scanin0};
  assign o1 = {busy1, done1, err1, mode1, jint1, scanen1, clkdr1, scanin1};

  // Wrapper chain: shifts toward bit 0 on each clkdr rise while scan-enabled.
  always @(posedge clkdr0 or posedge ld) begin
    if (ld)           chain0 <= pre0;
    else if (scanen0) chain0 <= {scanin0, chain0[7:1]};
  end
  always @(posedge clkdr1 or posedge ld) begin
    if (ld)           chain1 <= pre1;
    else if (scanen1) chain1 <= {scanin1, chain1[7:1]};
  end
  assign rxso0 = chain0[0];
  assign rxso1 = chain1[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Expected pins {busy,done,err,mode,intest,scanen,clkdr,scan_in} in the
  // cycle t clocks after the start edge. ab = cycle in which abort is driven.
  function automatic logic [7:0] exp_out(int t, int len, int div,
                                         logic [7:0] tx, logic it, int ab);
    logic b, d, e, m, i, s, c, si;
    b = 0; d = 0; e = 0; m = 0; i = 0; s = 0; c = 0; si = 0;
    if (len < 1 || len > 8) begin
      e = (t == 0);
    end else if (ab >= 0 && t > ab) begin
      e = (t == ab + 1);
    end else if (t < 2 * len * div) begin
      b = 1; m = 1; i = it; s = 1;
      c  = ((t % (2 * div)) >= div);
      si = tx[t / (2 * div)];
    end else if (t < 2 * (len + 1) * div) begin
      b = 1; m = 1; i = it;
      c = ((t - 2 * len * div) >= div);
    end else if (t == 2 * (len + 1) * div) begin
      d = 1;
    end
    return {b, d, e, m, i, s, c, si};
  endfunction

  // Bit k is sampled at the edge (2k+1)*div after start; an abort driven in
  // cycle ab takes effect at edge ab+1 and wins over a sample there.
  function automatic logic [7:0] exp_rx(int len, int div, logic [7:0] pre,
                                        int ab, logic [7:0] prev);
    logic [7:0] r;
    r = '0;
    if (len < 1 || len > 8) return prev;
    for (int k = 0; k < len; k++) begin
      if (ab < 0 || (2 * k + 1) * div <= ab) r[k] = pre[k];
    end
    return r;
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Entered just after a falling clock edge.
  task automatic run_op(input int len, input logic [7:0] tx, input logic it,
                        input logic [7:0] p0, input logic [7:0] p1,
                        input logic ab_with_start, input int ab,
                        input int st_t);
    int tmax;
    pre0 = p0; pre1 = p1;
    ld = 1'b1; #1 ld = 1'b0;
    start = 1'b1; op_len = 4'(len); tx_data = tx; intest_req = it;
    abort = ab_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tx_data = 8'($urandom); op_len = 4'($urandom); intest_req = 1'($urandom);
    if (len < 1 || len > 8) tmax = 3;
    else if (ab >= 0)       tmax = ab + 3;
    else                    tmax = 4 * (len + 1) + 1;
    for (int t = 0; t <= tmax; t++) begin
      check8($sformatf("pins_div2 len=%0d t=%0d", len, t), o0,
             exp_out(t, len, 2, tx, it, ab));
      check8($sformatf("pins_div1 len=%0d t=%0d", len, t), o1,
             exp_out(t, len, 1, tx, it, ab));
      start = 1'b0; abort = 1'b0;
      if (t == ab) abort = 1'b1;
      if (t == st_t) begin
        start = 1'b1; op_len = 4'($urandom_range(1, 8));
        tx_data = 8'($urandom); intest_req = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    rxp0 = exp_rx(len, 2, p0, ab, rxp0);
    rxp1 = exp_rx(len, 1, p1, ab, rxp1);
    check8($sformatf("rx_div2 len=%0d", len), rx0, rxp0);
    check8($sformatf("rx_div1 len=%0d", len), rx1, rxp1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_len = '0; tx_data = '0;
    intest_req = 1'b0; ld = 1'b0; pre0 = '0; pre1 = '0;
    rxp0 = '0; rxp1 = '0;

    #12;
    check8("reset_pins_div2", o0, 8'h00);
    check8("reset_pins_div1", o1, 8'h00);
    check8("reset_rx_div2", rx0, 8'h00);
    check8("reset_rx_div1", rx1, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Full-length shift of 0xA5 against a chain preloaded with 0x3C.
    run_op(8, 8'hA5, 1'b0, 8'h3C, 8'h3C, 1'b0, -1, -1);
    // Short shift with the chain returning all ones.
    run_op(3, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0, -1, -1);
    // Illegal lengths: error pulse only, rx_data untouched.
    run_op(0, 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0, -1, -1);
    run_op(9, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'b0, -1, -1);
    // Abort mid-shift.
    run_op(8, 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0, 5, -1);
    // Second start while busy is ignored.
    run_op(8, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'b0, -1, 2);
    // Start and abort on the same idle edge: start wins.
    run_op(5, 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b1, -1, -1);

    // Asynchronous reset in the middle of a shift.
    pre0 = 8'h96; pre1 = 8'h69; ld = 1'b1; #1 ld = 1'b0;
    start = 1'b1; op_len = 4'd8; tx_data = 8'h5A; intest_req = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check8("pre_reset_div2", o0, exp_out(9, 8, 2, 8'h5A, 1'b1, -1));
    check8("pre_reset_div1", o1, exp_out(9, 8, 1, 8'h5A, 1'b1, -1));
    @(posedge clk); #1 rst_n = 1'b0; #1;
    check8("midrst_pins_div2", o0, 8'h00);
    check8("midrst_pins_div1", o1, 8'h00);
    check8("midrst_rx_div2", rx0, 8'h00);
    check8("midrst_rx_div1", rx1, 8'h00);
    @(negedge clk); rst_n = 1'b1; rxp0 = '0; rxp1 = '0;
    @(negedge clk);
    run_op(6, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'b0, -1, -1);

    // Single-bit operation with intest selected.
    run_op(1, 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0, -1, -1);

    // Randomized operations.
    for (int n = 0; n < 6; n++) begin
      run_op(int'($urandom_range(1, 8)), 8'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
